// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA raster constants shared by the scan timer and the display logic.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic        VGA_SYNC_POL = 1'b0;
    localparam int unsigned VGA_CW       = 10;

endpackage

// File: rtl/vga_scan_timer_axis_counter.sv
// One raster axis: wrapping position counter with sync window and active-area decode.
// Sync is registered from the next count so it lines up with the count it describes.
module scan_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter int unsigned CW     = 10,
    parameter logic        POL    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap_c,
    output logic          sync,
    output logic          active_c
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_nxt;
    logic          sync_nxt;

    // Next position plus decodes of that position
    always_comb begin
        count_nxt = count;
        wrap_c    = 1'b0;
        if (step) begin
            if (count == LAST) begin
                count_nxt = '0;
                wrap_c    = 1'b1;
            end else begin
                count_nxt = count + CW'(1);
            end
        end
        active_c = (count_nxt < ACT_END);
        sync_nxt = ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? POL : ~POL;
    end

    // Preset to the last position so the first step lands on zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= LAST;
            sync  <= ~POL;
        end else begin
            count <= count_nxt;
            sync  <= sync_nxt;
        end
    end

endmodule

// File: rtl/vga_scan_timer.sv
// VGA scan timer: pixel/line counters, syncs, active flag and line/frame strobes.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_scan_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = VGA_SYNC_POL,
    parameter int unsigned CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          inDisplayArea,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
`ifdef VGA_FRAME_COUNT_EN
    output logic [7:0]    frame_cnt,
`endif
    output logic          line_start,
    output logic          frame_start
);

    logic h_wrap_c;
    logic v_wrap_c;
    logic h_active_c;
    logic v_active_c;
    logic v_step_c;

    assign v_step_c = pix_ce & h_wrap_c;

    scan_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW),
        .POL    (SYNC_POL)
    ) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .step     (pix_ce),
        .count    (CounterX),
        .wrap_c   (h_wrap_c),
        .sync     (vga_h_sync),
        .active_c (h_active_c)
    );

    scan_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW),
        .POL    (SYNC_POL)
    ) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .step     (v_step_c),
        .count    (CounterY),
        .wrap_c   (v_wrap_c),
        .sync     (vga_v_sync),
        .active_c (v_active_c)
    );

    // Flags decoded from the next position; strobes last only for the stepping cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            inDisplayArea <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            line_start  <= pix_ce & h_wrap_c;
            frame_start <= pix_ce & h_wrap_c & v_wrap_c;
            if (pix_ce) begin
                inDisplayArea <= h_active_c & v_active_c;
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (pix_ce & h_wrap_c & v_wrap_c) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: full-size raster vector table plus a shrunken raster
// instance for whole-frame and mid-frame reset behaviour.
module tb_vga_scan_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, ce_a = 1'b0;
    logic       rst_b = 1'b1, ce_b = 1'b0;
    logic [9:0] x_a, y_a;
    logic       hs_a, vs_a, de_a, ls_a, fs_a;
    logic [3:0] x_b, y_b;
    logic       hs_b, vs_b, de_b, ls_b, fs_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int checks   = 0;
    int failures = 0;

    vga_scan_timer dut_a (
        .clk           (clk),
        .reset         (rst_a),
        .pix_ce        (ce_a),
        .vga_h_sync    (hs_a),
        .vga_v_sync    (vs_a),
        .inDisplayArea (de_a),
        .CounterX      (x_a),
        .CounterY      (y_a),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt     (fc_a),
`endif
        .line_start    (ls_a),
        .frame_start   (fs_a)
    );

    // 15 x 10 raster: hsync at x 10..12, vsync on lines 7..8, active 8 x 6
    vga_scan_timer #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b0), .CW (4)
    ) dut_b (
        .clk           (clk),
        .reset         (rst_b),
        .pix_ce        (ce_b),
        .vga_h_sync    (hs_b),
        .vga_v_sync    (vs_b),
        .inDisplayArea (de_b),
        .CounterX      (x_b),
        .CounterY      (y_b),
`ifdef VGA_FRAME_COUNT_EN
        .frame_cnt     (fc_b),
`endif
        .line_start    (ls_b),
        .frame_start   (fs_b)
    );

    typedef struct {
        logic        rst;
        logic        ce;
        int          skip;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [24:0] pk(input int x, input int y, input bit hs, input bit vs,
                                       input bit de, input bit ls, input bit fs);
        return {10'(x), 10'(y), hs, vs, de, ls, fs};
    endfunction

    function automatic string fmt(input logic [24:0] v);
        return $sformatf("(x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b)",
                         v[24:15], v[14:5], v[4], v[3], v[2], v[1], v[0]);
    endfunction

    function automatic logic [24:0] out_a();
        return {x_a, y_a, hs_a, vs_a, de_a, ls_a, fs_a};
    endfunction

    function automatic logic [24:0] out_b();
        return {10'(x_b), 10'(y_b), hs_b, vs_b, de_b, ls_b, fs_b};
    endfunction

    task automatic check_pix(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%s required=%s", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc_a(input logic r, input logic c);
        @(negedge clk);
        rst_a = r;
        ce_a  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic r, input logic c);
        @(negedge clk);
        rst_b = r;
        ce_b  = c;
        @(posedge clk);
        #1;
    endtask

    // Reference for the small raster
    int mx, my;

    task automatic model_step();
        if (mx == 14) begin
            mx = 0;
            my = (my == 9) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    function automatic logic [24:0] exp_b(input int x, input int y, input bit ce_now);
        bit hs, vs, de, ls;
        hs = !(x >= 10 && x <= 12);
        vs = !(y >= 7 && y <= 8);
        de = (x < 8) && (y < 6);
        ls = ce_now && (x == 0);
        return pk(x, y, hs, vs, de, ls, ls && (y == 0));
    endfunction

    initial begin
        int since_fs, ls_in_frame, vs_low, fs_seen, n;

        tbl[0]  = '{1'b1, 1'b0, 0,    pk(799, 524, 1, 1, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, 0,    pk(0,   0,   1, 1, 1, 1, 1)};
        tbl[2]  = '{1'b0, 1'b0, 0,    pk(0,   0,   1, 1, 1, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, 0,    pk(1,   0,   1, 1, 1, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, 653,  pk(655, 0,   1, 1, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b1, 0,    pk(656, 0,   0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, 94,   pk(751, 0,   0, 1, 0, 0, 0)};
        tbl[7]  = '{1'b0, 1'b1, 0,    pk(752, 0,   1, 1, 0, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, 46,   pk(799, 0,   1, 1, 0, 0, 0)};
        tbl[9]  = '{1'b0, 1'b1, 0,    pk(0,   1,   1, 1, 1, 1, 0)};
        tbl[10] = '{1'b0, 1'b1, 7838, pk(639, 10,  1, 1, 1, 0, 0)};
        tbl[11] = '{1'b0, 1'b1, 0,    pk(640, 10,  1, 1, 0, 0, 0)};
        tbl[12] = '{1'b1, 1'b1, 0,    pk(799, 524, 1, 1, 0, 0, 0)};
        tbl[13] = '{1'b0, 1'b1, 0,    pk(0,   0,   1, 1, 1, 1, 1)};
        tbl[14] = '{1'b0, 1'b1, 699,  pk(700, 0,   0, 1, 0, 0, 0)};

        // Full-size raster: table of directed steps
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < tbl[i].skip; k++) cyc_a(1'b0, 1'b1);
            cyc_a(tbl[i].rst, tbl[i].ce);
            check_pix($sformatf("vec%0d", i), out_a(), tbl[i].exp);
`ifdef VGA_FRAME_COUNT_EN
            if (i == 1 || i == 13) check_val($sformatf("frame_cnt%0d", i), int'(fc_a), 1);
`endif
        end

        // pix_ce idle for 50 clocks inside the hsync window
        for (int k = 0; k < 50; k++) begin
            cyc_a(1'b0, 1'b0);
            check_pix($sformatf("hold%0d", k), out_a(), pk(700, 0, 0, 1, 0, 0, 0));
        end
        cyc_a(1'b0, 1'b1);
        check_pix("resume", out_a(), pk(701, 0, 0, 1, 0, 0, 0));
        ce_a = 1'b0;

        // Small raster: reset, then three frames at pix_ce every second clock
        cyc_b(1'b1, 1'b1);
        mx = 14;
        my = 9;
        check_pix("b_reset", out_b(), exp_b(mx, my, 1'b0));
        since_fs = 0; ls_in_frame = 0; vs_low = 0; fs_seen = 0;
        for (int c = 0; c < 900; c++) begin
            logic ce_now;
            ce_now = (c % 2) == 0;
            cyc_b(1'b0, ce_now);
            if (ce_now) model_step();
            check_pix($sformatf("b_run%0d", c), out_b(), exp_b(mx, my, ce_now));
            if (ce_now) begin
                if (fs_b) begin
                    if (fs_seen > 0) begin
                        check_val("frame_period", since_fs, 150);
                        check_val("lines_per_frame", ls_in_frame, 10);
                        check_val("vsync_low_ce", vs_low, 30);
                    end
                    fs_seen++;
                    since_fs = 0; ls_in_frame = 0; vs_low = 0;
                end
                since_fs++;
                if (ls_b) ls_in_frame++;
                if (!vs_b) vs_low++;
            end
        end
        check_val("frames_seen", fs_seen, 3);

        // Mid-frame reset at (5,4) while pix_ce is high
        n = 0;
        while (!(mx == 5 && my == 4) && n < 400) begin
            cyc_b(1'b0, 1'b1);
            model_step();
            n++;
        end
        check_val("reach_5_4", (mx == 5 && my == 4) ? 1 : 0, 1);
        check_pix("b_at_5_4", out_b(), exp_b(5, 4, 1'b1));
        cyc_b(1'b1, 1'b1);
        check_pix("b_midreset", out_b(), pk(14, 9, 1, 1, 0, 0, 0));
        cyc_b(1'b0, 1'b0);
        check_pix("b_postreset_idle", out_b(), pk(14, 9, 1, 1, 0, 0, 0));
        cyc_b(1'b0, 1'b1);
        check_pix("b_first_pixel", out_b(), pk(0, 0, 1, 1, 1, 1, 1));
        ce_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- Source end of the pixel-position/sync interface that the pong display logic consumes.
- Generates the horizontal and vertical scan counters, sync pulses, the active-area flag, and line/frame strobes for a 640x480 VGA raster.
- Pixel rate is set by a clock-enable from the top-level clock divider.
- All display-side logic (paddle, ball, colour registers) keys off these outputs.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of both sync outputs (0 = active-low)
CW, 10, counter width; H_TOTAL and V_TOTAL must be at most 2^CW

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_ce  in  1  pixel clock enable, one clk cycle wide
vga_h_sync  out  1  horizontal sync, registered
vga_v_sync  out  1  vertical sync, registered
inDisplayArea  out  1  high while CounterX < H_ACTIVE and CounterY < V_ACTIVE
CounterX  out  CW  current pixel column
CounterY  out  CW  current line
line_start  out  1  one-clk pulse when CounterX becomes 0
frame_start  out  1  one-clk pulse when (CounterX, CounterY) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (synchronous; highest priority; may occur mid-line or mid-frame):
  - CounterX = H_TOTAL-1, CounterY = V_TOTAL-1.
  - Both syncs at the inactive level (~SYNC_POL).
  - inDisplayArea = 0; line_start = 0; frame_start = 0.
  - This places the first pix_ce after reset at (0,0).
- On a clk edge with pix_ce=1 and reset=0:
  - CounterX: if H_TOTAL-1, wrap to 0; otherwise +1.
  - CounterY: advances only when CounterX wraps. If V_TOTAL-1, wrap to 0; otherwise +1.
- Output alignment:
  - Every output is registered and decoded from the next counter values.
  - Syncs, inDisplayArea and strobes therefore describe the same pixel as CounterX/CounterY in the same cycle. Zero latency between counters and flags.
- vga_h_sync is active (=SYNC_POL) for CounterX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
- vga_v_sync is active for CounterY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491]. It is a full-line-based window, changing only at CounterX=0.
- line_start and frame_start:
  - Each is high for exactly one clk cycle, the cycle in which the counter update occurred.
  - Both are cleared on any cycle with pix_ce=0.
  - frame_start implies line_start.
- pix_ce=0: all counters, syncs and inDisplayArea hold. Strobes drop to 0.
- pix_ce held high continuously is legal: one pixel per clk.
- Counter arithmetic is unsigned CW-bit. No value outside [0, TOTAL-1] is ever output.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_cnt, 8 bits, reset to 0.
  - Increments (mod 256) in the same cycle frame_start pulses, so the first frame after reset reads 1.
  - Used for animation pacing instead of raw divider bits.
- Undefined: port absent; no extra logic.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480@60 constants (the eight porch/sync/active values).
  - H_TOTAL/V_TOTAL derivations.
  - Sync polarity constant.
  - Shared by this block and the display logic.
- One natural sub-module, scan_axis_counter:
  - Parameterised by ACTIVE, FP, SYNC, BP and POL.
  - Inputs: step enable and a reset preset. Outputs: count, wrap, sync and active.
  - Instantiated twice: the horizontal instance is stepped by pix_ce; the vertical instance is stepped by pix_ce AND horizontal wrap.

Test Plan:
- Reset then 1 pix_ce -> CounterX=0, CounterY=0, inDisplayArea=1, line_start=1, frame_start=1, both syncs high (inactive).
- Step from CounterX=655 to 656 -> vga_h_sync falls to 0. At 751->752 it rises. Measured width is 96 pix_ce.
- Full frame at pix_ce every 2nd clk -> 420000 pix_ce between frame_starts, 525 line_starts per frame, vga_v_sync low for exactly 1600 pix_ce starting at (0,490).
- CounterX=639->640 on line 10 -> inDisplayArea falls. At line 480, inDisplayArea stays 0 for the whole line.
- Reset asserted at (300,200) for one cycle while pix_ce=1 -> next outputs are (799,524), syncs inactive, strobes 0. Next pix_ce gives (0,0) with frame_start.
- pix_ce low for 50 clk at CounterX=700 -> all outputs frozen, vga_h_sync stays 0, strobes 0 throughout.
